// File: rtl/adder_mon_if.sv
// Bus between a host/test harness and adder_error_monitor: run control,
// operands to the approximate adder, its returned sum and the error statistics.
interface adder_mon_if #(
    parameter int unsigned N = 16
);
    logic          start;
    logic [31:0]   num_tests;
    logic [N-1:0]  op_a;
    logic [N-1:0]  op_b;
    logic [N-1:0]  approx_sum;
    logic          busy;
    logic          done;
    logic [31:0]   err_count;
    logic [47:0]   sum_ed;
    logic [N-1:0]  max_ed;

    modport master (
        output start, num_tests, approx_sum,
        input  op_a, op_b, busy, done, err_count, sum_ed, max_ed
    );

    modport slave (
        input  start, num_tests, approx_sum,
        output op_a, op_b, busy, done, err_count, sum_ed, max_ed
    );
endinterface

// File: rtl/adder_error_monitor.sv
// Drives LFSR operands into an external approximate adder and accumulates error
// statistics. Define ADDER_MON_MAX_TRACK_EN to enable max_ed tracking (else max_ed is 0).
module adder_error_monitor #(
    parameter int unsigned N    = 16,
    parameter logic [31:0] SEED = 32'hACE1_2004
) (
    input  logic        clk,
    input  logic        rst_n,
    adder_mon_if.slave  bus
);

    localparam int unsigned CNT_W     = 32;
    localparam int unsigned SUM_W     = 48;
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   remaining;
    logic [CNT_W-1:0]   err_count_q;
    logic [SUM_W-1:0]   sum_ed_q;
    logic [31:0]        lfsr;
    logic [N-1:0]       op_a_q;
    logic [N-1:0]       op_b_q;
    logic               busy_q;
    logic               done_q;

    logic [31:0]        lfsr_next;
    logic [N-1:0]       exact;
    logic [N-1:0]       ed;
    logic               mismatch;

    // Galois step and error distance for the vector currently on op_a/op_b.
    always_comb begin
        lfsr_next = {1'b0, lfsr[31:1]};
        if (lfsr[0]) begin
            lfsr_next = lfsr_next ^ LFSR_MASK;
        end
        exact    = op_a_q + op_b_q;
        mismatch = (bus.approx_sum != exact);
        ed       = (bus.approx_sum >= exact) ? (bus.approx_sum - exact)
                                             : (exact - bus.approx_sum);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            remaining   <= '0;
            err_count_q <= '0;
            sum_ed_q    <= '0;
            lfsr        <= SEED;
            op_a_q      <= '0;
            op_b_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        err_count_q <= '0;
                        sum_ed_q    <= '0;
                        lfsr        <= SEED;
                        remaining   <= bus.num_tests;
                        op_a_q      <= SEED[N-1:0];
                        op_b_q      <= SEED[31 -: N];
                        if (bus.num_tests != '0) begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                        end else begin
                            state  <= FIN;
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    err_count_q <= err_count_q + CNT_W'(mismatch);
                    sum_ed_q    <= sum_ed_q + SUM_W'(ed);
                    lfsr        <= lfsr_next;
                    op_a_q      <= lfsr_next[N-1:0];
                    op_b_q      <= lfsr_next[31 -: N];
                    remaining   <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        state  <= FIN;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ADDER_MON_MAX_TRACK_EN
    logic [N-1:0] max_ed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_ed_q <= '0;
        end else if (state == IDLE && bus.start) begin
            max_ed_q <= '0;
        end else if (state == RUN && ed > max_ed_q) begin
            max_ed_q <= ed;
        end
    end

    assign bus.max_ed = max_ed_q;
`else
    assign bus.max_ed = '0;
`endif

    assign bus.op_a      = op_a_q;
    assign bus.op_b      = op_b_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err_count = err_count_q;
    assign bus.sum_ed    = sum_ed_q;

endmodule

// File: tb/tb_adder_error_monitor.sv
// Randomized self-checking bench for adder_error_monitor against a vector-list
// reference model; the stub adder corrupts the exact sum with per-run masks.
module tb_adder_error_monitor;

    localparam int unsigned N    = 16;
    localparam logic [31:0] SEED = 32'hACE1_2004;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    adder_mon_if #(.N(N)) bus ();

    adder_error_monitor #(.N(N), .SEED(SEED)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Stub approximate adder: exact sum with operand-dependent and fixed bit flips.
    logic [N-1:0] and_mask;
    logic [N-1:0] xor_mask;
    assign bus.approx_sum = N'(bus.op_a + bus.op_b) ^ (bus.op_a & and_mask) ^ xor_mask;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model: enumerate the operand sequence and tally statistics.
    longint unsigned m_err, m_sum, m_max;
    longint unsigned m_a[$];
    longint unsigned m_b[$];

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    task automatic model_run(input longint unsigned t);
        logic [31:0] s;
        longint unsigned lim, a, b, ex, ap, ed;
        s     = SEED;
        lim   = 64'd1 << N;
        m_err = 0;
        m_sum = 0;
        m_max = 0;
        m_a.delete();
        m_b.delete();
        for (longint unsigned i = 0; i < t; i++) begin
            a  = longint'(s) % lim;
            b  = longint'(s) >> (32 - N);
            ex = (a + b) % lim;
            ap = ex ^ (a & longint'(and_mask)) ^ longint'(xor_mask);
            ed = (ap > ex) ? (ap - ex) : (ex - ap);
            if (ap != ex) m_err++;
            m_sum = (m_sum + ed) % (64'd1 << 48);
            if (ed > m_max) m_max = ed;
            if (i < 64) begin
                m_a.push_back(a);
                m_b.push_back(b);
            end
            s = lfsr_step(s);
        end
`ifndef ADDER_MON_MAX_TRACK_EN
        m_max = 0;
`endif
    endtask

    int unsigned busy_cycles;
    logic [N-1:0] rec_a[$];
    logic [N-1:0] rec_b[$];

    // Start a run, then count busy cycles (bounded by stop_after); optional re-pulse of start.
    task automatic run(input logic [31:0] t, input int unsigned stop_after, input int unsigned repulse_at);
        @(negedge clk);
        bus.num_tests = t;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
        bus.num_tests = $urandom();
        busy_cycles   = 0;
        rec_a.delete();
        rec_b.delete();
        while (bus.busy && busy_cycles < stop_after) begin
            rec_a.push_back(bus.op_a);
            rec_b.push_back(bus.op_b);
            busy_cycles++;
            if (busy_cycles == repulse_at) begin
                bus.start     = 1'b1;
                bus.num_tests = 32'd7;
            end
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    task automatic check_ops(input string tag);
        int bad = 0;
        for (int i = 0; i < rec_a.size() && i < m_a.size(); i++) begin
            if (longint'(rec_a[i]) != m_a[i] || longint'(rec_b[i]) != m_b[i]) bad++;
        end
        check({tag, ".ops"}, longint'(bad), 0);
    endtask

    task automatic finish_checks(input string tag, input int unsigned t);
        check({tag, ".busy_cycles"}, longint'(busy_cycles), longint'(t));
        check({tag, ".done"}, longint'(bus.done), 1);
        check({tag, ".err_count"}, longint'(bus.err_count), m_err);
        check({tag, ".sum_ed"}, longint'(bus.sum_ed), m_sum);
        check({tag, ".max_ed"}, longint'(bus.max_ed), m_max);
        check_ops(tag);
        @(negedge clk);
        check({tag, ".done_pulse"}, longint'(bus.done), 0);
        repeat (3) @(negedge clk);
        check({tag, ".hold_err"}, longint'(bus.err_count), m_err);
        check({tag, ".hold_sum"}, longint'(bus.sum_ed), m_sum);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".busy"}, longint'(bus.busy), 0);
        check({tag, ".done"}, longint'(bus.done), 0);
        check({tag, ".err_count"}, longint'(bus.err_count), 0);
        check({tag, ".sum_ed"}, longint'(bus.sum_ed), 0);
        check({tag, ".max_ed"}, longint'(bus.max_ed), 0);
        check({tag, ".op_a"}, longint'(bus.op_a), 0);
        check({tag, ".op_b"}, longint'(bus.op_b), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned t;
        bus.start     = 1'b0;
        bus.num_tests = '0;
        and_mask      = '0;
        xor_mask      = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;

        model_run(1000);
        run(32'd1000, 1020, 0);
        finish_checks("exact1000", 1000);

        xor_mask = N'(1);
        model_run(100);
        run(32'd100, 120, 0);
        finish_checks("xor1", 100);

        xor_mask = N'(3);
        model_run(100);
        run(32'd100, 120, 0);
        finish_checks("xor3", 100);

        xor_mask = '0;
        model_run(0);
        run(32'd0, 5, 0);
        finish_checks("zero_tests", 0);

        and_mask = N'($urandom());
        model_run(50);
        run(32'd50, 70, 5);
        finish_checks("repulse", 50);

        for (int k = 0; k < 6; k++) begin
            and_mask = N'($urandom());
            xor_mask = N'($urandom_range(0, 7));
            t        = $urandom_range(1, 300);
            model_run(longint'(t));
            run(t, t + 20, 0);
            finish_checks($sformatf("rand%0d", k), t);
        end

        // Mid-run reset, then a fresh short run must replay the seed sequence.
        and_mask = N'($urandom());
        xor_mask = '0;
        model_run(20);
        run(32'd100, 20, 0);
        check("midrst.busy_before", longint'(bus.busy), 1);
        check("midrst.err_before", longint'(bus.err_count), m_err);
        check("midrst.sum_before", longint'(bus.sum_ed), m_sum);
        check_ops("midrst.first");
        rst_n = 1'b0;
        #1;
        check_zero("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        model_run(10);
        run(32'd10, 30, 0);
        finish_checks("after_rst", 10);

        // Maximum count: must still be running with correct partial statistics.
        and_mask = N'($urandom());
        model_run(200);
        run(32'hFFFF_FFFF, 200, 0);
        check("maxcnt.busy_cycles", longint'(busy_cycles), 200);
        check("maxcnt.busy", longint'(bus.busy), 1);
        check("maxcnt.err_count", longint'(bus.err_count), m_err);
        check("maxcnt.sum_ed", longint'(bus.sum_ed), m_sum);
        check_ops("maxcnt");
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adder_error_monitor.md
ADDER_ERROR_MONITOR -- requirements
Module: adder_error_monitor

Interface
REQ-001 SHALL provide parameter N, default 16, meaning operand/sum width of the adder under test; legal range 4..16.
REQ-002 SHALL provide parameter SEED, default 32'hACE1_2004, meaning nonzero LFSR seed reloaded at each start.
REQ-003 SHALL provide clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL provide rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL provide start  input  1  one-cycle request to begin a measurement run.
REQ-006 SHALL provide num_tests  input  32  number of test vectors, sampled when start is accepted.
REQ-007 SHALL provide op_a, op_b  output  N each  registered operands to the external approximate adder.
REQ-008 SHALL provide approx_sum  input  N  combinational sum returned by the approximate adder for op_a/op_b.
REQ-009 SHALL provide busy  output  1  high while a run is in progress.
REQ-010 SHALL provide done  output  1  one-cycle pulse at run completion.
REQ-011 SHALL provide err_count  output  32  number of vectors where approx_sum differs from exact sum.
REQ-012 SHALL provide sum_ed  output  48  accumulated absolute error distance.
REQ-013 SHALL provide max_ed  output  N  largest single error distance seen in the run.

Function
REQ-014 SHALL implement states IDLE, RUN, FIN; IDLE->RUN on start with num_tests!=0; IDLE->FIN on start with num_tests==0; RUN->FIN when remaining count reaches 0; FIN->IDLE unconditionally after one cycle.
REQ-015 SHALL, on accepted start, clear err_count, sum_ed, max_ed, load LFSR with SEED, load remaining counter with num_tests, and drive op_a=SEED[N-1:0], op_b=SEED[31:32-N] from the next cycle.
REQ-016 SHALL use a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1 (mask 32'h8020_0003), advancing exactly once per evaluated vector.
REQ-017 SHALL, in each RUN cycle, sample approx_sum at the clock edge, compute exact = (op_a+op_b) mod 2^N, ed = |approx_sum - exact| as N-bit unsigned magnitude, and update accumulators in the same edge.
REQ-018 SHALL increment err_count when approx_sum != exact; add ed to sum_ed with 48-bit wrap; set max_ed = ed when ed > max_ed.
REQ-019 SHALL evaluate one vector per clock: a run of T vectors holds busy high for exactly T cycles, with done asserted in the cycle after the last RUN cycle.
REQ-020 SHALL ignore start while busy or in FIN; num_tests changes during a run have no effect.
REQ-021 SHALL hold err_count, sum_ed, max_ed stable from done until the next accepted start.
REQ-022 SHALL hold op_a/op_b at their last values outside RUN.
REQ-023 SHALL support num_tests=32'hFFFF_FFFF without counter overflow or early termination.

Reset
REQ-024 SHALL, on rst_n low at any time including mid-run, asynchronously force state IDLE, busy=0, done=0, err_count=0, sum_ed=0, max_ed=0, op_a=0, op_b=0, LFSR=SEED, remaining=0.
REQ-025 SHALL require a fresh start after reset release; no partial run resumes.

Configuration
REQ-026 SHALL honour macro ADDER_MON_MAX_TRACK_EN: defined -> max_ed tracking per REQ-018; undefined -> max_ed comparator and register omitted, max_ed tied to 0.

Verification
REQ-027 Stub approx_sum = exact, num_tests=1000 -> busy 1000 cycles, done pulse, err_count=0, sum_ed=0, max_ed=0.
REQ-028 Stub approx_sum = exact ^ 1, num_tests=100 -> err_count=100, sum_ed=100, max_ed=1.
REQ-029 num_tests=0, start -> busy never high, done next cycle, all results 0.
REQ-030 start re-pulsed at cycle 5 of a 50-vector run -> ignored, run ends after 50 cycles, results equal an uninterrupted run.
REQ-031 rst_n low at cycle 20 of a 100-vector run -> all outputs 0 immediately, IDLE; new start with num_tests=10 reproduces the first 10 operand pairs of the original run (SEED repeatability).
REQ-032 Build without ADDER_MON_MAX_TRACK_EN, stub approx_sum = exact ^ 3 -> max_ed=0, err_count and sum_ed as with macro defined.
